servo_pwm_driver: RTL

//   Converts the 8-bit servo_angle code from servo_fsm into a hobby-servo PWM pulse train.

---
 rtl/servo_pwm_driver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator: one pulse per period whose width is MIN_TICKS plus
// STEP_TICKS per angle LSB, with a one-clock done strobe at each period boundary.
module servo_pwm_driver #(
    parameter int CLK_DIV      = 50,
    parameter int PERIOD_TICKS = 20000,
    parameter int MIN_TICKS    = 1000,
    parameter int STEP_TICKS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] servo_angle,
    output logic       pwm_out,
    output logic       servo_cycle_done,
    output logic [7:0] angle_q
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if ((CLK_DIV < 1) || (PERIOD_TICKS > 65535) || (MIN_TICKS < 1) || (STEP_TICKS < 0) ||
            ((MIN_TICKS + 255 * STEP_TICKS) >= PERIOD_TICKS)) begin : g_bad_params
            $error("servo_pwm_driver: illegal timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [17:0]      pulse_q, pulse_d;
    logic [7:0]       ang_q, ang_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;

    logic tick_s;
    logic high_end_s;
    logic period_end_s;
    logic start_s;

    // Tick qualifiers; cnt_q counts ticks since period start across both HIGH and LOW.
    always_comb begin
        tick_s       = (pre_q == PRE_W'(CLK_DIV - 1));
        high_end_s   = (state_q == ST_HIGH) && tick_s && ({2'b00, cnt_q} == (pulse_q - 18'd1));
        period_end_s = (state_q == ST_LOW) && tick_s && (cnt_q == 16'(PERIOD_TICKS - 1));
        if (state_q == ST_IDLE) begin
            start_s = en;
        end else begin
            start_s = period_end_s && en;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_HIGH;
                else    state_d = ST_IDLE;
            end
            ST_HIGH: begin
                if (high_end_s) state_d = ST_LOW;
                else            state_d = ST_HIGH;
            end
            ST_LOW: begin
                if (period_end_s) state_d = en ? ST_HIGH : ST_IDLE;
                else              state_d = ST_LOW;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; pwm simply mirrors the HIGH state one edge early.
    always_comb begin
        pwm_d  = (state_d == ST_HIGH);
        done_d = period_end_s;
        if (start_s) begin
            ang_d   = servo_angle;
            pulse_d = 18'(MIN_TICKS) + (18'(servo_angle) * 18'(STEP_TICKS));
            pre_d   = {PRE_W{1'b0}};
            cnt_d   = 16'd0;
        end else if ((state_q == ST_IDLE) || period_end_s) begin
            ang_d   = ang_q;
            pulse_d = pulse_q;
            pre_d   = {PRE_W{1'b0}};
            cnt_d   = 16'd0;
        end else if (tick_s) begin
            ang_d   = ang_q;
            pulse_d = pulse_q;
            pre_d   = {PRE_W{1'b0}};
            cnt_d   = cnt_q + 16'd1;
        end else begin
            ang_d   = ang_q;
            pulse_d = pulse_q;
            pre_d   = pre_q + PRE_W'(1);
            cnt_d   = cnt_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= {PRE_W{1'b0}};
            cnt_q   <= 16'd0;
            pulse_q <= 18'd0;
            ang_q   <= 8'h80;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            ang_q   <= ang_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign pwm_out          = pwm_q;
    assign servo_cycle_done = done_q;
    assign angle_q          = ang_q;

endmodule
